// File: rtl/emu_transactor_gen.sv
// Co-emulation transactor between the emulator byte bus and a DUT.
// The emulator writes stimulus bytes into a shadow bank and loads the whole bank onto the
// DUT inputs in one cycle. It can capture all DUT output bytes at once and read them back
// one byte at a time. A step engine pulses the DUT clock enable for N back-to-back cycles.
// When AUTO_GET is set, the engine captures the DUT outputs once they have settled.
module emu_transactor_gen #(
  parameter int NUM_STIM = 1,
  parameter int NUM_OUT  = 3,
  parameter int ADDR_W   = 3,
  parameter int AUTO_GET = 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [7:0]            Din_emu,
  input  logic [ADDR_W-1:0]     Addr_emu,
  input  logic                  wr_emu,
  input  logic                  load_emu,
  input  logic                  get_emu,
  input  logic                  step_emu,
  output logic [7:0]            Dout_emu,
  output logic [NUM_STIM*8-1:0] stim_o,
  input  logic [NUM_OUT*8-1:0]  dut_i,
  output logic                  dut_ce,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t     state;
  logic [7:0] cnt;
  logic       cap_pend;
  logic [7:0] stim_in  [NUM_STIM];
  logic [7:0] vect_out [NUM_OUT];
  logic [7:0] rd_data;

  // Read-back mux: an address beyond the capture bank reads as zero
  always_comb begin
    rd_data = 8'h00;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (Addr_emu == ADDR_W'(k)) rd_data = vect_out[k];
    end
  end

  // Registered read-back; runs every cycle, including while a step is in progress
  always_ff @(posedge ap_clk) begin
    if (ap_rst) Dout_emu <= 8'h00;
    else        Dout_emu <= rd_data;
  end

  // Command decoder and step FSM. Commands are accepted only in IDLE or DONE.
  // In those states the priority is load, get, step, write.
  // cap_pend marks a DONE state that follows a real run. The auto-capture then samples
  // the DUT after its last enabled edge. A zero-length step does not capture.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state    <= ST_IDLE;
      cnt      <= 8'h00;
      cap_pend <= 1'b0;
      dut_ce   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      stim_o   <= '0;
      for (int k = 0; k < NUM_STIM; k++) stim_in[k] <= 8'h00;
      for (int k = 0; k < NUM_OUT; k++) vect_out[k] <= 8'h00;
    end else begin
      case (state)
        ST_RUN: begin
          if (cnt == 8'd1) begin
            state    <= ST_DONE;
            cnt      <= 8'h00;
            cap_pend <= 1'b1;
            dut_ce   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          cap_pend <= 1'b0;
          dut_ce   <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          if ((AUTO_GET != 0) && (state == ST_DONE) && cap_pend) begin
            for (int k = 0; k < NUM_OUT; k++) vect_out[k] <= dut_i[8*k +: 8];
          end
          if (load_emu) begin
            for (int k = 0; k < NUM_STIM; k++) stim_o[8*k +: 8] <= stim_in[k];
          end else if (get_emu) begin
            for (int k = 0; k < NUM_OUT; k++) vect_out[k] <= dut_i[8*k +: 8];
          end else if (step_emu) begin
            if (Din_emu != 8'h00) begin
              state  <= ST_RUN;
              cnt    <= Din_emu;
              dut_ce <= 1'b1;
              busy   <= 1'b1;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end else if (wr_emu) begin
            for (int k = 0; k < NUM_STIM; k++) begin
              if (Addr_emu == ADDR_W'(k)) stim_in[k] <= Din_emu;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_emu_transactor_gen.sv
// Directed-plus-random bench for emu_transactor_gen with its default parameters
// (NUM_STIM=1, NUM_OUT=3, ADDR_W=3, AUTO_GET=1).
// The DUT model is an 8-bit counter that advances on every dut_ce cycle.
// Expected values come from a byte-level model of the stimulus and capture banks.
module tb_emu_transactor_gen;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic [7:0]  Din_emu = 8'h00;
  logic [2:0]  Addr_emu = 3'd0;
  logic        wr_emu = 1'b0;
  logic        load_emu = 1'b0;
  logic        get_emu = 1'b0;
  logic        step_emu = 1'b0;
  logic [7:0]  Dout_emu;
  logic [7:0]  stim_o;
  logic [23:0] dut_i;
  logic        dut_ce;
  logic        busy;
  logic        done;

  logic [23:0] manual_i = 24'h000000;
  logic        use_ctr = 1'b0;
  logic [7:0]  dut_count = 8'h00;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] stim_m;
  logic [7:0] vect_m [3];

  emu_transactor_gen dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .Din_emu(Din_emu), .Addr_emu(Addr_emu),
    .wr_emu(wr_emu), .load_emu(load_emu), .get_emu(get_emu), .step_emu(step_emu),
    .Dout_emu(Dout_emu), .stim_o(stim_o), .dut_i(dut_i), .dut_ce(dut_ce),
    .busy(busy), .done(done)
  );

  // Free-running emulator clock
  always #5 ap_clk = ~ap_clk;

  // Stand-in DUT: a counter that advances only on enabled cycles
  always @(posedge ap_clk) begin
    if (dut_ce) dut_count <= dut_count + 8'd1;
  end

  assign dut_i = use_ctr ? {16'h0000, dut_count} : manual_i;

  task automatic cycle();
    @(posedge ap_clk);
    @(negedge ap_clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] modelRead(input int a);
    return (a < 3) ? vect_m[a] : 8'h00;
  endfunction

  task automatic readCheck(input int a);
    Addr_emu = 3'(a);
    cycle();
    checkOutput($sformatf("read_addr%0d", a), {24'h0, Dout_emu}, {24'h0, modelRead(a)});
  endtask

  task automatic applyStimulus(input logic w, input logic l, input logic g, input logic s,
                               input logic [7:0] d, input logic [2:0] a);
    wr_emu = w; load_emu = l; get_emu = g; step_emu = s; Din_emu = d; Addr_emu = a;
    cycle();
    wr_emu = 1'b0; load_emu = 1'b0; get_emu = 1'b0; step_emu = 1'b0;
  endtask

  // Issue a step of n cycles and check the shape of the enable window, the single done
  // pulse that follows it, and, for n>0 with the counter DUT, the auto-captured value
  task automatic runStep(input int n, input string tag);
    logic [7:0] start;
    int ce_cnt, done_idx;
    logic shape_ok;
    start = dut_count;
    ce_cnt = 0; done_idx = -1; shape_ok = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'(n), 3'd0);
    for (int i = 0; i < 300 && done_idx < 0; i++) begin
      if (dut_ce !== (i < n) || busy !== (i < n)) shape_ok = 1'b0;
      ce_cnt += int'(dut_ce);
      if (done === 1'b1) done_idx = i;
      else cycle();
    end
    checkOutput({tag, "_ce_count"}, ce_cnt, n);
    checkOutput({tag, "_done_index"}, done_idx, n);
    checkOutput({tag, "_window"}, {31'h0, shape_ok}, 32'd1);
    cycle();
    checkOutput({tag, "_done_pulse_end"}, {31'h0, done}, 32'd0);
    if (n > 0 && use_ctr) begin
      vect_m[0] = start + 8'(n); vect_m[1] = 8'h00; vect_m[2] = 8'h00;
      readCheck(0);
    end
  endtask

  initial begin
    logic [7:0] b, x, y;
    logic [7:0] start;
    int n, n1, n2, ce_cnt, done_cnt, first_i;
    logic seen, gap_ok;

    for (int k = 0; k < 3; k++) vect_m[k] = 8'h00;
    stim_m = 8'h00;

    // Power-up reset
    @(negedge ap_clk);
    cycle();
    cycle();
    ap_rst = 1'b0;
    checkOutput("reset_stim_o", {24'h0, stim_o}, 32'h0);
    checkOutput("reset_dout", {24'h0, Dout_emu}, 32'h0);
    checkOutput("reset_ce_busy_done", {29'h0, dut_ce, busy, done}, 32'h0);

    // Reset in the middle of a 10-cycle run aborts it without a done pulse
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 3'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0);
    checkOutput("pre_reset_load", {24'h0, stim_o}, 32'h5A);
    use_ctr = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd10, 3'd0);
    cycle(); cycle();
    ap_rst = 1'b1;
    cycle();
    checkOutput("midrun_reset_ce_busy_done", {29'h0, dut_ce, busy, done}, 32'h0);
    checkOutput("midrun_reset_stim_o", {24'h0, stim_o}, 32'h0);
    checkOutput("midrun_reset_dout", {24'h0, Dout_emu}, 32'h0);
    cycle();
    ap_rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1 || dut_ce === 1'b1 || busy === 1'b1) seen = 1'b1;
      cycle();
    end
    checkOutput("midrun_reset_no_done", {31'h0, seen}, 32'h0);
    stim_m = 8'h00;
    for (int k = 0; k < 3; k++) vect_m[k] = 8'h00;
    readCheck(0);

    // Write then load; out-of-range writes are dropped
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 3'd0);
    stim_m = 8'hA5;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0);
    checkOutput("load_a5", {24'h0, stim_o}, {24'h0, stim_m});
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h3E, 3'd5);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0);
    checkOutput("wr_addr5_ignored", {24'h0, stim_o}, {24'h0, stim_m});
    for (int r = 0; r < 4; r++) begin
      b = 8'($urandom);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, b, 3'd0);
      stim_m = b;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0);
      checkOutput($sformatf("load_rand%0d", r), {24'h0, stim_o}, {24'h0, stim_m});
    end

    // Get and byte-wise read-back, including addresses past the capture bank
    use_ctr = 1'b0;
    manual_i = 24'h3C1B07;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
    vect_m[0] = 8'h07; vect_m[1] = 8'h1B; vect_m[2] = 8'h3C;
    readCheck(0); readCheck(1); readCheck(2); readCheck(6);
    manual_i = 24'($urandom);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0);
    for (int k = 0; k < 3; k++) vect_m[k] = manual_i[8*k +: 8];
    for (int a = 0; a < 8; a++) readCheck(a);

    // Step engine with the counter DUT and auto-capture
    use_ctr = 1'b1;
    runStep(5, "step5");
    runStep(0, "step0");
    for (int r = 0; r < 3; r++) begin
      n = int'($urandom_range(1, 20));
      runStep(n, $sformatf("step_rand%0d", r));
    end
    runStep(255, "step255");

    // load, get and step together: only load is taken
    use_ctr = 1'b0;
    x = 8'($urandom);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, x, 3'd0);
    stim_m = x;
    manual_i = 24'($urandom);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'd3, 3'd0);
    checkOutput("combo_load_taken", {24'h0, stim_o}, {24'h0, stim_m});
    checkOutput("combo_no_step", {30'h0, dut_ce, busy}, 32'h0);
    cycle();
    checkOutput("combo_no_done", {31'h0, done}, 32'h0);
    readCheck(0); readCheck(2);

    // Writes while busy are ignored
    y = x ^ 8'hFF;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 3'd0);
    wr_emu = 1'b1; Din_emu = y; Addr_emu = 3'd0;
    cycle(); cycle();
    wr_emu = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done === 1'b1) seen = 1'b1;
      else cycle();
    end
    checkOutput("busy_wr_done_seen", {31'h0, seen}, 32'd1);
    cycle();
    for (int k = 0; k < 3; k++) vect_m[k] = manual_i[8*k +: 8];
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0);
    checkOutput("busy_wr_ignored", {24'h0, stim_o}, {24'h0, stim_m});
    readCheck(2);

    // Back-to-back steps: the second step is issued in the DONE cycle
    use_ctr = 1'b1;
    n1 = int'($urandom_range(1, 15));
    n2 = int'($urandom_range(1, 15));
    start = dut_count;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'(n1), 3'd0);
    ce_cnt = 0; done_cnt = 0; first_i = -10; gap_ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (i == first_i + 1) begin
        step_emu = 1'b0;
        gap_ok = (dut_ce === 1'b1);
      end
      ce_cnt += int'(dut_ce);
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) begin
          first_i = i;
          Din_emu = 8'(n2);
          step_emu = 1'b1;
        end else begin
          break;
        end
      end
      cycle();
    end
    step_emu = 1'b0;
    checkOutput("b2b_done_count", done_cnt, 2);
    checkOutput("b2b_ce_total", ce_cnt, n1 + n2);
    checkOutput("b2b_no_idle_gap", {31'h0, gap_ok}, 32'd1);
    cycle();
    vect_m[0] = start + 8'(n1 + n2); vect_m[1] = 8'h00; vect_m[2] = 8'h00;
    readCheck(0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
